seq_restoring_divider: RTL and testbench

- Multi-cycle restoring integer divider for the CPU's M-extension path. It is the subtract-direction counterpart of the ripple-carry adder.
- Each cycle, one trial subtraction runs through a ripple-borrow chain of full-subtractor cells, producing one quotient bit per cycle.
- It sits beside the ALU, accepts operands on a valid/ready handshake and returns quotient and remainder together.
- Results follow RISC-V DIV/DIVU/REM/REMU semantics, including divide-by-zero and signed overflow.

---
 rtl/seq_restoring_divider_pkg.sv | 27 ++
 rtl/seq_restoring_divider_one_bit_ripple_borrow.sv | 16 +
 rtl/seq_restoring_divider.sv | 181 ++++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default width and constant helpers evaluated at elaboration time.
package seq_restoring_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand width for the M-extension datapath.
    localparam int unsigned DIV_WIDTH = 32;

    // Widest operand the constant helpers below can describe.
    localparam int unsigned MAX_WIDTH = 256;

    // Counter width for the CALC iteration counter; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Most negative two's-complement value of a w-bit word, LSB-aligned.
    function automatic logic [MAX_WIDTH-1:0] min_neg(input int unsigned w);
        return MAX_WIDTH'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_one_bit_ripple_borrow.sv
// Full-subtractor cell: out = in0 - in1 - bin, bout = borrow to next bit.
module one_bit_ripple_borrow (
    input  logic bin,
    input  logic in0,
    input  logic in1,
    output logic out,
    output logic bout
);

    // Difference bit and borrow-out of a single subtractor stage.
    always_comb begin
        out  = in0 ^ in1 ^ bin;
        bout = (~in0 & in1) | (~(in0 ^ in1) & bin);
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// One quotient bit per CALC cycle via a ripple-borrow trial subtraction.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = WIDTH'(min_neg(WIDTH));

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] cnt;
    // Partial remainder keeps only its low WIDTH bits: the stored value is
    // always below |divisor|, so bit WIDTH of R is zero between iterations.
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] dvs_mag;
    logic             neg_q;
    logic             neg_r;

    logic             dvd_neg;
    logic             dvs_neg;
    logic             div_zero;
    logic             overflow;
    logic             special;
    logic             last_iter;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] borrow;
    logic             final_borrow;
    logic             unused_trial_msb;

    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

    // Operand classification, evaluated on the accept cycle.
    always_comb begin
        dvd_neg   = in_signed & dividend[WIDTH-1];
        dvs_neg   = in_signed & divisor[WIDTH-1];
        div_zero  = (divisor == '0);
        overflow  = in_signed & (dividend == MIN_NEG) & (divisor == '1);
        special   = div_zero | overflow;
        last_iter = (cnt == CNT_LAST);
    end

    // Shift in the next dividend bit and form the zero-extended subtrahend.
    always_comb begin
        r_shift = {rem_acc, quo_acc[WIDTH-1]};
        sub_b   = {1'b0, dvs_mag};
    end

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < WIDTH + 1; i++) begin : g_borrow_chain
        one_bit_ripple_borrow u_cell (
            .bin  (borrow[i]),
            .in0  (r_shift[i]),
            .in1  (sub_b[i]),
            .out  (trial[i]),
            .bout (borrow[i+1])
        );
    end

    // A successful trial always leaves bit WIDTH clear, so it is never kept.
    assign unused_trial_msb = trial[WIDTH];
    assign final_borrow     = borrow[WIDTH+1];

    // Restore-or-keep decision plus sign fix-up for the final iteration.
    always_comb begin
        quo_step  = {quo_acc[WIDTH-2:0], ~final_borrow};
        rem_step  = final_borrow ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_final = neg_q ? -quo_step : quo_step;
        rem_final = neg_r ? -rem_step : rem_step;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem_acc   <= '0;
            quo_acc   <= '0;
            dvs_mag   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt     <= '0;
                        rem_acc <= '0;
                        quo_acc <= dvd_neg ? -dividend : dividend;
                        dvs_mag <= dvs_neg ? -divisor : divisor;
                        neg_q   <= dvd_neg ^ dvs_neg;
                        neg_r   <= dvd_neg;
                        if (div_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end else if (overflow) begin
                            quotient  <= dividend;
                            remainder <= '0;
                        end
                    end
                end
                CALC: begin
                    rem_acc <= rem_step;
                    quo_acc <= quo_step;
                    cnt     <= last_iter ? '0 : cnt + 1'b1;
                    if (last_iter) begin
                        quotient  <= quo_final;
                        remainder <= rem_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench: table-driven vectors, random ops against a
// behavioural model, backpressure, input-hold and mid-operation reset.
module tb_seq_restoring_divider;

    localparam int unsigned W = 32;
    localparam logic [W-1:0] ONES    = '1;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } exp_t;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           hold;
        bit           scramble;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // RISC-V division semantics from the language's own operators.
    function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = ONES; e.r = a; e.lat = 1;
        end else if (sgn && a == MIN_NEG && b == ONES) begin
            e.q = a; e.r = '0; e.lat = 1;
        end else if (sgn) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
            e.lat = W + 1;
        end else begin
            e.q = a / b; e.r = a % b; e.lat = W + 1;
        end
        return e;
    endfunction

    task automatic do_op(input string tag, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input exp_t e, input int hold,
                         input bit scramble);
        exp_t got;
        int   cyc;
        int   guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        check($sformatf("%s_in_ready_idle", tag), W'(in_ready), W'(1));
        sb.push_back(e);
        out_ready = (hold == 0);
        in_signed = sgn; dividend = a; divisor = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        check($sformatf("%s_busy", tag), W'(busy), W'(1));
        check($sformatf("%s_in_ready_busy", tag), W'(in_ready), W'(0));
        while (!out_valid && cyc < 200) begin
            if (scramble) begin
                dividend  = $urandom;
                divisor   = $urandom;
                in_signed = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        got = sb.pop_front();
        check($sformatf("%s_latency", tag), W'(cyc), W'(got.lat));
        check($sformatf("%s_quotient", tag), quotient, got.q);
        check($sformatf("%s_remainder", tag), remainder, got.r);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s_hold%0d_valid", tag, i), W'(out_valid), W'(1));
            check($sformatf("%s_hold%0d_q", tag, i), quotient, got.q);
            check($sformatf("%s_hold%0d_r", tag, i), remainder, got.r);
            check($sformatf("%s_hold%0d_in_ready", tag, i), W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s_consumed", tag), W'(out_valid), W'(0));
        check($sformatf("%s_in_ready_after", tag), W'(in_ready), W'(1));
        check($sformatf("%s_idle_busy", tag), W'(busy), W'(0));
    endtask

    initial begin
        exp_t         e;
        exp_t         m;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        0,  1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 1'b0};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        0,  1'b0};
        vecs[3]  = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        0,  1'b0};
        vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       0,  1'b0};
        vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        10, 1'b0};
        vecs[6]  = '{1'b0, 32'd1000,       32'd10,       32'd100,      32'd0,        0,  1'b1};
        vecs[7]  = '{1'b1, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        0,  1'b0};
        vecs[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 0, 1'b0};
        vecs[9]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 1'b0};
        vecs[10] = '{1'b0, 32'd7,          32'd100,      32'd0,        32'd7,        0,  1'b0};
        vecs[11] = '{1'b1, 32'h8000_0000,  32'd1,        32'h8000_0000, 32'd0,        0,  1'b0};

        // Reset values while rst_n is held low.
        #3;
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_quotient", quotient, '0);
        check("rst_remainder", remainder, '0);
        #9;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            m = model(vecs[i].sgn, vecs[i].a, vecs[i].b);
            e.q = vecs[i].q;
            e.r = vecs[i].r;
            e.lat = m.lat;
            do_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, e,
                  vecs[i].hold, vecs[i].scramble);
        end

        for (int k = 0; k < 16; k++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = W'($urandom_range(1, 15));
                1: b = -W'($urandom_range(1, 15));
                2: b = '0;
                default: b = $urandom >> $urandom_range(0, 24);
            endcase
            e = model(sgn, a, b);
            do_op($sformatf("rnd%0d", k), sgn, a, b, e, k % 3, 1'b0);
        end

        // Mid-CALC reset: leave a known non-zero result in the output registers first.
        e = model(1'b0, 32'd100, 32'd7);
        do_op("pre_reset", 1'b0, 32'd100, 32'd7, e, 0, 1'b0);
        in_signed = 1'b0; dividend = 32'd12345; divisor = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("abort_busy_before", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", W'(in_ready), W'(1));
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_busy", W'(busy), W'(0));
        check("abort_quotient", quotient, '0);
        check("abort_remainder", remainder, '0);
        #4;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_still_idle", W'(out_valid | busy), W'(0));
        end
        e.q = 32'd3; e.r = 32'd0; e.lat = W + 1;
        do_op("post_reset", 1'b0, 32'd9, 32'd3, e, 0, 1'b0);

        check("scoreboard_empty", W'(sb.size()), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
